// File: rtl/clock_step_controller_pkg.sv
// clock_step_controller_pkg: mode encoding and period multiplier table
package clock_step_controller_pkg;
  typedef enum logic [1:0] {PAUSE = 2'd0, RUN = 2'd1, HALTED = 2'd2} mode_e;
  localparam logic [3:0] PERIOD_MULT [4] = '{4'd1, 4'd2, 4'd5, 4'd10};
endpackage

// File: rtl/clock_step_controller_if.sv
// clock_step_controller_if: key/switch inputs and processor tick outputs
interface clock_step_controller_if #(parameter int CNT_W = 32);
  logic run_key_n;
  logic step_key_n;
  logic [1:0] period_sel;
  logic cpu_halt;
  logic tick;
  logic running;
  logic halted;
  logic tick_led;
  logic [CNT_W-1:0] tick_count;
  modport master (
    input run_key_n, step_key_n, period_sel, cpu_halt,
    output tick, running, halted, tick_led, tick_count
  );
  modport slave (
    output run_key_n, step_key_n, period_sel, cpu_halt,
    input tick, running, halted, tick_led, tick_count
  );
endinterface

// File: rtl/clock_step_controller_key_debounce.sv
// clock_step_controller_key_debounce: key synchronizer, debouncer and press pulse
module clock_step_controller_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q;
  logic armed_q, armed_d;
  logic level_q, level_d;
  logic prev_q;
  logic press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic diff, hit;
  // sync flops reset to pressed so a key held through reset never arms the debouncer
  always_comb begin
    diff = armed_q && (!s2_q != level_q);
    hit = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    armed_d = armed_q | s2_q;
    cnt_d = diff && !hit ? cnt_q + CW'(1) : '0;
    level_d = diff && hit ? !level_q : level_q;
    press_d = level_q && !prev_q;
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      prev_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
      armed_q <= armed_d;
      level_q <= level_d;
      prev_q <= level_q;
      press_q <= press_d;
      cnt_q <= cnt_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/clock_step_controller.sv
// clock_step_controller: run/step/pause/halt scheduler producing the processor tick
module clock_step_controller
  import clock_step_controller_pkg::*;
#(
  parameter int BASE_DIV = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 32
) (
  input logic CLOCK_50,
  input logic reset,
  clock_step_controller_if.master bus
);
  mode_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;
  logic [CNT_W-1:0] period;
  logic [1:0] sel_q;
  logic tick_q, tick_d;
  logic tick_led_q, tick_led_d;
  logic run_press, step_press, sel_chg, expire;
  clock_step_controller_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .key_n(bus.run_key_n),
    .press(run_press)
  );
  clock_step_controller_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .key_n(bus.step_key_n),
    .press(step_press)
  );
  always_comb begin
    period = CNT_W'(BASE_DIV) * CNT_W'(PERIOD_MULT[bus.period_sel]);
    sel_chg = bus.period_sel != sel_q;
    expire = cnt_q == period - CNT_W'(1);
    state_d = state_q;
    cnt_d = cnt_q;
    tick_d = 1'b0;
    if (bus.cpu_halt) begin
      state_d = HALTED;
      cnt_d = '0;
    end else if (state_q == PAUSE) begin
      state_d = run_press ? RUN : PAUSE;
      tick_d = step_press && !run_press;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      state_d = run_press ? PAUSE : RUN;
      tick_d = !run_press && !sel_chg && expire;
      cnt_d = run_press || sel_chg || expire ? '0 : cnt_q + CNT_W'(1);
    end
    tick_led_d = tick_led_q ^ tick_d;
    tick_count_d = tick_count_q + CNT_W'(tick_d);
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= PAUSE;
      cnt_q <= '0;
      sel_q <= 2'd0;
      tick_q <= 1'b0;
      tick_led_q <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= bus.period_sel;
      tick_q <= tick_d;
      tick_led_q <= tick_led_d;
      tick_count_q <= tick_count_d;
    end
  end
  assign bus.tick = tick_q;
  assign bus.running = state_q == RUN;
  assign bus.halted = state_q == HALTED;
  assign bus.tick_led = tick_led_q;
  assign bus.tick_count = tick_count_q;
endmodule

// File: tb/tb_clock_step_controller.sv
// tb_clock_step_controller: scoreboard bench checking tick timing, counts and mode outputs
module tb_clock_step_controller;
  localparam int BASE_DIV = 4;
  localparam int DEB = 3;
  localparam int CNT_W = 32;
  typedef struct {
    int at;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  clock_step_controller_if #(.CNT_W(CNT_W)) bus ();
  clock_step_controller #(
    .BASE_DIV(BASE_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .bus(bus)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
  endtask
  always @(negedge CLOCK_50) begin
    if (bus.tick === 1'b1) begin
      if (sb.size() == 0) check("spurious_tick", bus.tick, 1'b0);
      else begin
        mon_e = sb.pop_front();
        check("tick_cycle", cyc, mon_e.at);
        check("tick_count", bus.tick_count, mon_e.cnt);
        check("tick_led", bus.tick_led, mon_e.cnt[0]);
      end
    end else if (sb.size() > 0 && cyc > sb[0].at) begin
      void'(sb.pop_front());
      check("missing_tick", bus.tick, 1'b1);
    end
  end
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask
  task automatic at_neg(input int c);
    wait_cyc(c);
    @(negedge CLOCK_50);
  endtask
  task automatic push_tick(input int at);
    exp_cnt++;
    sb.push_back('{at: at, cnt: CNT_W'(exp_cnt)});
  endtask
  task automatic key(input bit step, input int k, input int hold);
    wait_cyc(k);
    if (step) bus.step_key_n = 1'b0;
    else bus.run_key_n = 1'b0;
    wait_cyc(k + hold);
    if (step) bus.step_key_n = 1'b1;
    else bus.run_key_n = 1'b1;
  endtask
  task automatic assert_reset();
    reset = 1'b0;
    #1;
    check("rst_tick", bus.tick, 1'b0);
    check("rst_running", bus.running, 1'b0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_tick_led", bus.tick_led, 1'b0);
    check("rst_tick_count", bus.tick_count, 0);
    sb.delete();
    exp_cnt = 0;
  endtask
  task automatic release_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
  endtask
  initial begin
    int k, m, p, r;
    bus.run_key_n = 1'b1;
    bus.step_key_n = 1'b1;
    bus.period_sel = 2'd0;
    bus.cpu_halt = 1'b0;
    #1;
    assert_reset();
    release_reset();
    r = cyc;
    at_neg(r + 50);
    check("idle_count", bus.tick_count, 0);
    check("idle_running", bus.running, 1'b0);
    check("idle_halted", bus.halted, 1'b0);
    p = cyc + 2;
    for (int i = 0; i < 3; i++) begin
      k = p + 15 * i;
      push_tick(k + 7);
      key(1'b1, k, 5);
    end
    key(1'b1, p + 50, 2);
    at_neg(p + 80);
    check("step_count", bus.tick_count, 3);
    check("step_led", bus.tick_led, 1'b1);
    check("step_running", bus.running, 1'b0);
    assert_reset();
    release_reset();
    k = cyc + 5;
    m = k + 28;
    for (int t = k + 11; t < m + 7; t += 4) push_tick(t);
    key(1'b0, k, 10);
    at_neg(k + 27);
    check("run_count", bus.tick_count, 5);
    check("run_running", bus.running, 1'b1);
    check("run_led", bus.tick_led, 1'b1);
    key(1'b0, m, 10);
    at_neg(m + 12);
    check("pause_running", bus.running, 1'b0);
    check("pause_count", bus.tick_count, 6);
    check("pause_halted", bus.halted, 1'b0);
    k = cyc + 5;
    push_tick(k + 11);
    push_tick(k + 15);
    push_tick(k + 59);
    key(1'b0, k, 10);
    wait_cyc(k + 18);
    bus.period_sel = 2'd3;
    at_neg(k + 19);
    check("sel_chg_no_tick", bus.tick, 1'b0);
    check("sel_chg_running", bus.running, 1'b1);
    wait_cyc(k + 98);
    bus.cpu_halt = 1'b1;
    wait_cyc(k + 99);
    bus.cpu_halt = 1'b0;
    @(negedge CLOCK_50);
    check("halt_tick", bus.tick, 1'b0);
    check("halt_halted", bus.halted, 1'b1);
    check("halt_running", bus.running, 1'b0);
    check("halt_count", bus.tick_count, 9);
    key(1'b1, k + 105, 6);
    key(1'b0, k + 125, 6);
    at_neg(k + 150);
    check("halted_count", bus.tick_count, 9);
    check("halted_sticky", bus.halted, 1'b1);
    check("halted_running", bus.running, 1'b0);
    bus.period_sel = 2'd0;
    assert_reset();
    release_reset();
    k = cyc + 5;
    for (int n = 0; n < 7; n++) push_tick(k + 11 + 4 * n);
    key(1'b0, k, 10);
    at_neg(k + 37);
    check("run7_count", bus.tick_count, 7);
    check("run7_running", bus.running, 1'b1);
    check("run7_led", bus.tick_led, 1'b1);
    bus.run_key_n = 1'b0;
    assert_reset();
    release_reset();
    r = cyc;
    at_neg(r + 30);
    check("held_running", bus.running, 1'b0);
    check("held_count", bus.tick_count, 0);
    wait_cyc(r + 31);
    bus.run_key_n = 1'b1;
    k = r + 45;
    push_tick(k + 11);
    push_tick(k + 15);
    key(1'b0, k, 10);
    at_neg(k + 16);
    check("repress_running", bus.running, 1'b1);
    check("repress_count", bus.tick_count, 2);
    check("sb_empty", sb.size(), 0);
    assert_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clock_step_controller.md
Name: clock_step_controller

Overview:
- Run/step/pause scheduler that generates the processor's clock-enable tick from CLOCK_50.
- Sits between the board keys/switches and the pipelined processor, which advances one stage only on a cycle where tick=1.
- Supports free-running ticks at a selectable period of 1/2/5/10 base units, single-step on a key press, and sticky halt on processor request.

Parameters:
- BASE_DIV, 50000000, CLOCK_50 cycles per base unit (1 s); small values for simulation.
- DEBOUNCE_CYCLES, 500000, cycles a synchronized key must stay stable before its new level is accepted.
- CNT_W, 32, width of the period counter and tick_count.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low; resets all state.
- run_key_n  in  1  raw run/pause button, active-low, asynchronous to CLOCK_50.
- step_key_n  in  1  raw step button, active-low, asynchronous.
- period_sel  in  2  00=1x, 01=2x, 10=5x, 11=10x BASE_DIV.
- cpu_halt  in  1  processor halt request, synchronous to CLOCK_50.
- tick  out  1  single-cycle clock enable for the processor.
- running  out  1  high in RUN state.
- halted  out  1  high in HALTED state.
- tick_led  out  1  toggles on every tick.
- tick_count  out  CNT_W  ticks issued since reset; wraps at 2^CNT_W.

Behaviour:
- Reset values: tick=0, running=0, halted=0, tick_led=0, tick_count=0. Period counter=0, FSM=PAUSE, debouncer outputs=released.
- Key conditioning: each key passes through a 2-flop synchronizer and then a debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples. A press event is a single-cycle pulse on the debounced released->pressed edge.
- Minimum press-to-event latency: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- period = BASE_DIV * {1,2,5,10}[period_sel], computed combinationally. The 10x value with the default BASE_DIV must fit in CNT_W.
- FSM states:
  - PAUSE: run press -> RUN (period counter cleared). Step press -> tick=1 for exactly one cycle; the FSM stays in PAUSE.
  - RUN: the period counter increments each cycle. When counter == period-1: tick=1 and the counter wraps to 0. Run press -> PAUSE (counter cleared, no tick that cycle). Step press is ignored.
  - HALTED: no ticks; all key presses are ignored. Exit only via reset.
- cpu_halt=1 in any state -> HALTED on the next edge. tick is forced to 0 in the same cycle cpu_halt is high; halt beats a coincident period expiry or step.
- run press and step press in the same cycle in PAUSE: run wins, no step tick.
- period_sel change while in RUN: the counter is cleared on the cycle the change is detected (registered compare). The next tick comes a full new period later. No tick is issued on the change cycle even if the counter equalled the old period-1.
- Each tick increments tick_count and toggles tick_led in the same cycle tick is registered (outputs update on the clock edge after the decision).
- tick is a registered output: at most one cycle wide, never high on two consecutive cycles unless period==1.
- Reset asserted mid-run: all outputs return to reset values asynchronously. A key held through reset release produces no press event until it is released and pressed again.

Decomposition:
- Shared package: mode encoding constants (PAUSE, RUN, HALTED) and the period multiplier table {1,2,5,10}.
- One sub-module: key_debounce (synchronizer, stability counter, debounced level, press pulse), instantiated twice.

Test Plan (BASE_DIV=4, DEBOUNCE_CYCLES=3):
- Reset then idle 50 cycles -> tick never 1, tick_count=0, running=0.
- Run press held 10 cycles, period_sel=00 -> running=1; ticks every 4 cycles; tick_count=5 after 20 cycles in RUN; tick_led toggles on each tick.
- In PAUSE, three step presses with release between -> exactly 3 single-cycle ticks, tick_count=3. A 2-cycle glitch on step_key_n -> no tick.
- RUN with period_sel switched 00->11 mid-period -> no tick on the switch cycle; the next tick comes exactly 40 cycles after the counter clear.
- cpu_halt pulsed on the same cycle as a period expiry -> tick=0 that cycle, halted=1; later run/step presses produce no ticks.
- Reset asserted in RUN with tick_count=7 -> all outputs 0 immediately. Run key held through reset release -> stays PAUSE until a release and a new press.
